// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream handshake and instruction-memory write bus used
//               by the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    // Loader side: consumes the stream, drives the memory write port.
    modport slave (
        input  in_valid, in_byte,
        output in_ready, wr_en, wr_addr, wr_data
    );

    // Host side: produces the stream, observes the memory write port.
    modport master (
        output in_valid, in_byte,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Framed serial loader for the MIPS instruction memory.
//               Frame = LEN_HI, LEN_LO, 4*N big-endian data bytes, XOR
//               checksum of the data bytes. Holds the CPU until a frame
//               with a good checksum has been written.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  wire logic     clk,
    input  wire logic     reset,
    input  wire logic     start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [16:0] c_MAX_WORDS = 17'(2 ** ADDR_WIDTH);

    state_t                r_state;
    state_t                w_state_nx;
    logic [7:0]            r_len_hi;
    logic [15:0]           r_len;
    logic [7:0]            r_xor;
    logic [ADDR_WIDTH:0]   r_index;
    logic [1:0]            r_cnt;
    logic [23:0]           r_word;
    logic                  r_wr_en;
    logic [31:0]           r_wr_addr;
    logic [31:0]           r_wr_data;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_start_load;
    logic [15:0]           w_len;
    logic                  w_oversize;
    logic [ADDR_WIDTH:0]   w_index_inc;
    logic                  w_last_word;

    assign w_ready      = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                          (r_state == S_DATA)   || (r_state == S_CHECK);
    assign w_accept     = bus.in_valid && w_ready;
    assign w_start_load = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                    (r_state == S_ERROR));
    assign w_len        = {r_len_hi, bus.in_byte};
    assign w_oversize   = {1'b0, w_len} > c_MAX_WORDS;
    assign w_index_inc  = r_index + {{ADDR_WIDTH{1'b0}}, 1'b1};
    // Index is bounded by the length check, so it never wraps.
    assign w_last_word  = (17'(w_index_inc) == {1'b0, r_len});

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode from the registered state and the accepted byte.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) w_state_nx = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_accept) w_state_nx = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    if (w_oversize)        w_state_nx = S_ERROR;
                    else if (w_len == 16'd0) w_state_nx = S_CHECK;
                    else                   w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept && (r_cnt == 2'd3) && w_last_word) w_state_nx = S_CHECK;
            end
            S_CHECK: begin
                if (w_accept) w_state_nx = (bus.in_byte == r_xor) ? S_DONE : S_ERROR;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Length capture, word assembly, checksum and the one-cycle write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len_hi  <= '0;
            r_len     <= '0;
            r_xor     <= '0;
            r_index   <= '0;
            r_cnt     <= '0;
            r_word    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_start_load) begin
                r_xor   <= '0;
                r_index <= '0;
                r_cnt   <= '0;
            end
            if (w_accept && (r_state == S_LEN_HI)) begin
                r_len_hi <= bus.in_byte;
            end
            if (w_accept && (r_state == S_LEN_LO)) begin
                r_len <= w_len;
            end
            if (w_accept && (r_state == S_DATA)) begin
                r_xor  <= r_xor ^ bus.in_byte;
                r_cnt  <= r_cnt + 2'd1;
                r_word <= {r_word[15:0], bus.in_byte};
                if (r_cnt == 2'd3) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= 32'({r_index, 2'b00});
                    r_wr_data <= {r_word, bus.in_byte};
                    r_index   <= w_index_inc;
                end
            end
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERROR);
    assign cpu_hold     = (r_state != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. A frame-level model
//               follows the accepted stream and predicts every output on
//               every cycle; directed and random frames drive it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_WIDTH = 8;
    localparam int MAXW       = 2 ** ADDR_WIDTH;

    logic clk;
    logic reset;
    logic start;
    logic cpu_hold;
    logic done;
    logic error;

    imem_loader_if bus ();

    imem_loader #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ERR = 3;
    int          m_st = M_IDLE;
    int          m_pos;
    int          m_n;
    logic [7:0]  m_x;
    logic [31:0] m_word;
    bit          m_we = 0;
    logic [31:0] m_addr, m_data;
    int          nwr = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
            chk("rst_wr_en",    32'(bus.wr_en),    32'd0);
            chk("rst_cpu_hold", 32'(cpu_hold),     32'd1);
            chk("rst_done",     32'(done),         32'd0);
            chk("rst_error",    32'(error),        32'd0);
            m_st = M_IDLE;
            m_we = 0;
        end else begin
            chk("wr_en", 32'(bus.wr_en), 32'(m_we));
            if (bus.wr_en) begin
                log_addr.push_back(bus.wr_addr);
                log_data.push_back(bus.wr_data);
                nwr++;
                if (m_we) begin
                    chk("wr_addr", bus.wr_addr, m_addr);
                    chk("wr_data", bus.wr_data, m_data);
                end
            end
            chk("done",     32'(done),         32'(m_st == M_DONE));
            chk("error",    32'(error),        32'(m_st == M_ERR));
            chk("cpu_hold", 32'(cpu_hold),     32'(m_st != M_DONE));
            chk("in_ready", 32'(bus.in_ready), 32'(m_st == M_RUN));
            m_we = 0;
            if (m_st != M_RUN && start) begin
                m_st = M_RUN; m_pos = 0; m_x = 8'h00; m_n = 0;
            end else if (m_st == M_RUN && bus.in_valid) begin
                if (m_pos == 0) begin
                    m_n = int'(bus.in_byte) * 256;
                end else if (m_pos == 1) begin
                    m_n = m_n + int'(bus.in_byte);
                    if (m_n > MAXW) m_st = M_ERR;
                end else if (m_pos < 2 + 4 * m_n) begin
                    m_x    = m_x ^ bus.in_byte;
                    m_word = {m_word[23:0], bus.in_byte};
                    if ((m_pos - 2) % 4 == 3) begin
                        m_we   = 1;
                        m_addr = 32'(((m_pos - 2) / 4) * 4);
                        m_data = m_word;
                    end
                end else begin
                    m_st = (bus.in_byte == m_x) ? M_DONE : M_ERR;
                end
                m_pos++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    // Offer each byte until accepted; optional random stalls and start pokes.
    task automatic send(input logic [7:0] q[$], input int stall, input bit poke);
        foreach (q[i]) begin
            bit sent = 0;
            int g = 0;
            while (!sent) begin
                start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
                if (stall > 0 && $urandom_range(0, 99) < stall) begin
                    bus.in_valid = 1'b0;
                    bus.in_byte  = 8'($urandom);
                end else begin
                    bus.in_valid = 1'b1;
                    bus.in_byte  = q[i];
                end
                sent = bus.in_valid && bus.in_ready;
                @(posedge clk); #2;
                g++;
                if (g > 2000) begin
                    chk("accept_timeout", 32'(g), 32'd0);
                    break;
                end
            end
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic void build(input int n, input bit good, output logic [7:0] q[$]);
        logic [7:0] x = 8'h00;
        q = {};
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            logic [7:0] b = 8'($urandom);
            q.push_back(b);
            x ^= b;
        end
        q.push_back(good ? x : ~x);
    endfunction

    logic [7:0] fr[$];
    logic [7:0] normal[$];
    int         base;

    initial begin
        normal = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
        reset = 1'b1; start = 1'b0;
        bus.in_valid = 1'b0; bus.in_byte = 8'h00;
        idle(3);
        chk("rst_wr_addr", bus.wr_addr, 32'h0);
        chk("rst_wr_data", bus.wr_data, 32'h0);
        reset = 1'b0;
        idle(2);

        // Normal load
        base = nwr;
        pulse_start(); send(normal, 0, 0); idle(3);
        chk("norm_nwr",   32'(nwr - base), 32'd2);
        chk("norm_a0",    log_addr[base],     32'h0);
        chk("norm_d0",    log_data[base],     32'h20080005);
        chk("norm_a1",    log_addr[base + 1], 32'h4);
        chk("norm_d1",    log_data[base + 1], 32'h0);
        chk("norm_done",  32'(done),     32'd1);
        chk("norm_hold",  32'(cpu_hold), 32'd0);
        chk("norm_ready", 32'(bus.in_ready), 32'd0);

        // Bad checksum, then recovery
        base = nwr;
        fr = normal; fr[10] = 8'h2C;
        pulse_start(); send(fr, 0, 0); idle(3);
        chk("bad_nwr",   32'(nwr - base), 32'd2);
        chk("bad_error", 32'(error),    32'd1);
        chk("bad_done",  32'(done),     32'd0);
        chk("bad_hold",  32'(cpu_hold), 32'd1);
        pulse_start(); send(normal, 0, 0); idle(3);
        chk("recover_done", 32'(done), 32'd1);

        // Empty frame
        base = nwr;
        fr = '{8'h00, 8'h00, 8'h00};
        pulse_start(); send(fr, 0, 0); idle(3);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_nwr",  32'(nwr - base), 32'd0);

        // Oversize frame (257 words)
        base = nwr;
        fr = '{8'h01, 8'h01};
        pulse_start(); send(fr, 0, 0); idle(1);
        chk("over_error", 32'(error), 32'd1);
        chk("over_ready", 32'(bus.in_ready), 32'd0);
        idle(3);
        chk("over_nwr",   32'(nwr - base), 32'd0);

        // Stalls with start pokes during the frame
        base = nwr;
        pulse_start(); send(normal, 40, 1); idle(3);
        chk("stall_nwr",  32'(nwr - base), 32'd2);
        chk("stall_d0",   log_data[base],     32'h20080005);
        chk("stall_a1",   log_addr[base + 1], 32'h4);
        chk("stall_done", 32'(done), 32'd1);

        // Full-capacity frame
        base = nwr;
        build(MAXW, 1, fr);
        pulse_start(); send(fr, 0, 0); idle(3);
        chk("full_nwr",   32'(nwr - base), 32'(MAXW));
        chk("full_alast", log_addr[nwr - 1], 32'(4 * (MAXW - 1)));
        chk("full_done",  32'(done), 32'd1);

        // Random frames
        for (int t = 0; t < 12; t++) begin
            bit good = 1'($urandom_range(0, 3) != 0);
            build(int'($urandom_range(0, 9)), good, fr);
            pulse_start(); send(fr, int'($urandom_range(0, 50)), 1'($urandom_range(0, 1)));
            idle(3);
            chk("rand_done", 32'(done), 32'(good));
        end

        // Reset mid-frame, then a clean load from address 0
        base = nwr;
        fr = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00};
        pulse_start(); send(fr, 0, 0);
        reset = 1'b1;
        idle(1);
        chk("mid_wr_en",   32'(bus.wr_en),   32'd0);
        chk("mid_wr_addr", bus.wr_addr,      32'h0);
        chk("mid_wr_data", bus.wr_data,      32'h0);
        chk("mid_hold",    32'(cpu_hold),    32'd1);
        idle(2);
        reset = 1'b0;
        idle(2);
        chk("mid_nwr", 32'(nwr - base), 32'd0);
        pulse_start(); send(normal, 0, 0); idle(3);
        chk("mid_reload_a0", log_addr[base], 32'h0);
        chk("mid_reload_d0", log_data[base], 32'h20080005);
        chk("mid_reload_done", 32'(done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Serial program loader that writes the instruction memory that the single-cycle MIPS processor fetches from. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each completed word is written to instruction memory at the word-aligned byte address the processor's PC uses. The loader holds the processor (`cpu_hold`) until a complete frame with a correct checksum has been loaded.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: word-address bits of instruction memory. Capacity is 2**ADDR_WIDTH words.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a load; honoured only in IDLE, DONE or ERROR.
- `in_valid`  in  1  `in_byte` is valid.
- `in_byte`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `wr_en`  out  1  one-cycle instruction-memory write strobe.
- `wr_addr`  out  32  byte address of the write, always word-aligned, equal to {index, 2'b00} zero-extended.
- `wr_data`  out  32  instruction word to write.
- `cpu_hold`  out  1  holds the processor's PC/register state; released only in DONE.
- `done`  out  1  load completed with a good checksum.
- `error`  out  1  load aborted.

## Operation
- Frame format:
  - LEN_HI byte, then LEN_LO byte, forming 16-bit word count N.
  - Then 4·N data bytes, first byte of each word in [31:24].
  - Then one checksum byte equal to the XOR of all data bytes. Length bytes are excluded from the checksum.
- A byte is accepted on a rising edge where `in_valid && in_ready`. `in_valid` low cycles simply stall the loader.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
- `in_ready` = 1 exactly in LEN_HI, LEN_LO, DATA and CHECK. It is decoded from the registered state.
- Transitions:
  - IDLE —`start`→ LEN_HI.
  - LEN_HI —accept→ LEN_LO.
  - LEN_LO —accept→ ERROR if N > 2**ADDR_WIDTH; else CHECK if N = 0; else DATA.
  - DATA: a 2-bit byte counter shifts bytes into a word register. On acceptance of the 4th byte, the word index increments. After the 4th byte of word N-1, the state goes to CHECK.
  - CHECK —accept→ DONE if the byte equals the running XOR, else ERROR.
  - DONE / ERROR —`start`→ LEN_HI. Entering LEN_HI clears `done`, `error`, the running XOR, the index and the byte counter, and sets `cpu_hold` = 1.
- `start` is ignored in LEN_HI, LEN_LO, DATA and CHECK.
- Index counter is ADDR_WIDTH+1 bits, which allows the value 2**ADDR_WIDTH. No wrap-around is possible because N is bounded.
- `cpu_hold` = 1 in every state except DONE.

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready` = 0, `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0.
  - `cpu_hold` = 1, `done` = 0, `error` = 0.
  - Running XOR = 0, index = 0.
- Write latency: `wr_en` pulses high for exactly one cycle, in the cycle after the edge that accepted the 4th byte of a word. `wr_addr` and `wr_data` are valid in that cycle and hold their values until the next write.
- Back-to-back words, one byte per cycle, give one `wr_en` every 4 cycles.
- The checksum byte may be accepted in the same cycle as the final `wr_en`.
- After the checksum byte is accepted at edge k, `done` = 1 and `cpu_hold` = 0 from edge k onward.
- On error, `error` = 1 from the accepting edge onward. No further writes occur. Memory contents already written stay as they are.
- Reset asserted mid-frame immediately forces all reset values, including `wr_en` = 0. A partial word is never written.

## Test plan
- **Reset:** assert `reset` with stream idle → `cpu_hold` = 1, `in_ready` = 0, `done` = 0, `error` = 0, `wr_en` = 0.
- **Normal load:** `start`, then bytes 00 02 | 20 08 00 05 | 00 00 00 00 | 2D, one per cycle → exactly two writes: (addr 0x0, data 0x20080005) and (addr 0x4, data 0x00000000). Then `done` = 1, `cpu_hold` = 0, `in_ready` = 0.
- **Bad checksum:** same frame with checksum 2C → both writes occur, then `error` = 1, `done` = 0, `cpu_hold` = 1. A following `start` plus a correct frame ends with `done` = 1.
- **Empty and oversize frames:**
  - 00 00 00 → `done` = 1 with no `wr_en`.
  - With ADDR_WIDTH = 8, 01 01 → `error` = 1 right after LEN_LO, with no writes and `in_ready` = 0.
- **Stalls:** normal frame with `in_valid` toggled randomly, and `start` pulsed during DATA → identical writes and result; `start` has no effect.
- **Reset mid-frame:** after 00 01 20 08 00, assert `reset` → no `wr_en` and all outputs at reset values. A subsequent `start` plus a full frame loads correctly from address 0.
